// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// The address check is shared so the responder and any future users of the array agree on legality.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_LAT_W  = 4;

  // Word aligned and inside the 2^addr_width word array.
  function automatic logic dmem_addr_ok(input logic [31:0] addr, input int addr_width);
    logic [31:0] hi;
    hi = addr >> (addr_width + 2);
    return (addr[1:0] == 2'b00) && (hi == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write mask; read data registered one edge after the address.
// No reset on contents: the array holds whatever was last written.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [3:0]             be,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, response LATENCY edges after accept, held until resp_ready.
// Backpressure: req_ready only in IDLE; DMEM_BYTE_EN adds the req_be byte-enable port for stores.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [DMEM_DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]             req_be,
`endif
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DMEM_DATA_W-1:0] resp_rdata,
  output logic                   resp_err
);

  localparam logic [DMEM_LAT_W-1:0] LAT_M1 = DMEM_LAT_W'(LATENCY - 1);

  dmem_state_t            state, state_nxt;
  logic [DMEM_LAT_W-1:0]  cnt;
  logic                   write_q;
  logic [31:0]            addr_q;
  logic [DMEM_DATA_W-1:0] wdata_q;
  logic [3:0]             be_q;
  logic                   rd_sel;
  logic [DMEM_DATA_W-1:0] ram_rdata;
  logic                   accept, commit, addr_ok, mem_we;

  assign accept    = (state == IDLE) && req_valid;
  assign commit    = (state == WAIT) && (cnt == '0);
  assign addr_ok   = dmem_addr_ok(addr_q, ADDR_WIDTH);
  // Gate with reset so a store caught in WAIT by reset never reaches the array.
  assign mem_we    = commit && write_q && addr_ok && !reset;
  assign req_ready = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rd_sel ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)  state_nxt = WAIT;
      WAIT:    if (cnt == '0)  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'hF;
      rd_sel   <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= LAT_M1;
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
`ifdef DMEM_BYTE_EN
        be_q    <= req_be;
`else
        be_q    <= 4'hF;
`endif
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end

      // The RAM read of the latched address lands on the commit edge; rd_sel picks it up for loads only.
      if (commit) begin
        rd_sel   <= !write_q && addr_ok;
        resp_err <= !addr_ok;
      end else if (resp_valid && resp_ready) begin
        rd_sel   <= 1'b0;
        resp_err <= 1'b0;
      end
    end
  end

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (be_q),
    .addr  (addr_q[ADDR_WIDTH+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a reference word model and response scoreboard.
// Build with DMEM_BYTE_EN defined to exercise the byte-enable path.
module tb_data_mem_responder;

  localparam int AW  = 10;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_EN
    .req_be     (req_be),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,          32'd0);
    check({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
  endtask

  // Bounded wait for resp_valid; returns edges elapsed since the call.
  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid) check("resp_timeout", {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Full transaction: model update, scoreboard push, accept, latency, hold window, handshake.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int hold, input logic early_rdy);
    exp_t        e;
    logic        ok;
    logic [3:0]  m;
    logic [31:0] w;
    int          idx, n;
    ok  = (addr[1:0] == 2'b00) && ((addr >> 2) < (32'd1 << AW));
    idx = int'(addr >> 2);
`ifdef DMEM_BYTE_EN
    m = be;
`else
    m = 4'hF;
`endif
    e.err   = !ok;
    e.rdata = (!wr && ok) ? model[idx] : 32'd0;
    if (wr && ok) begin
      w = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
      for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = wd[8*i +: 8];
      model[idx] = w;
    end
    sb.push_back(e);

    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    resp_ready = early_rdy;
    drive_req(wr, addr, wd, be);
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    wait_resp(n);
    check("latency", n, LAT);
    e = sb.pop_front();
    check("resp_rdata", resp_rdata, e.rdata);
    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});

    // Stalled response: outputs stay put and stray requests (stores to 0x10) are ignored.
    for (int k = 0; k < hold; k++) begin
      req_valid = k[0];
      req_write = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'h0BAD_0000 + k;
      @(posedge clk); #1;
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, e.rdata);
      check("hold_err", {31'd0, resp_err}, {31'd0, e.err});
    end
    req_valid = 1'b0;

    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_idle_outputs("post_hs");
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = 4'hF;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_outputs("reset");

    // Basic store/load, store response carries zero data.
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    send(1'b0, 32'h10, 32'h0,        4'hF, 0, 1'b0);
    send(1'b1, 32'h40, 32'h12345678, 4'hF, 0, 1'b0);
    send(1'b0, 32'h40, 32'h0,        4'hF, 0, 1'b0);
    send(1'b1, 32'h0,  32'hCAFE0000, 4'hF, 0, 1'b0);
    send(1'b1, 32'h80, 32'h55555555, 4'hF, 0, 1'b0);

    // Misaligned and out-of-range requests error out and leave the array alone.
    send(1'b0, 32'h2,    32'h0,        4'hF, 0, 1'b0);
    send(1'b0, 32'h1000, 32'h0,        4'hF, 0, 1'b0);
    send(1'b1, 32'h12,   32'hBAD0BAD0, 4'hF, 0, 1'b0);
    send(1'b1, 32'h1000, 32'hBAD1BAD1, 4'hF, 0, 1'b0);
    send(1'b0, 32'h10,   32'h0,        4'hF, 0, 1'b0);
    send(1'b0, 32'h0,    32'h0,        4'hF, 0, 1'b0);

    // Stalled response window, then early resp_ready.
    send(1'b0, 32'h40, 32'h0, 4'hF, 5, 1'b0);
    send(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0);
    send(1'b0, 32'h0,  32'h0, 4'hF, 0, 1'b1);

    // Reset one cycle after accepting a store: store dropped.
    drive_req(1'b1, 32'h80, 32'hAAAAAAAA, 4'hF);
    check("abort_busy", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle_outputs("abort_wait");
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    send(1'b0, 32'h80, 32'h0, 4'hF, 0, 1'b0);

    // Reset in RESP: response discarded, committed store kept.
    model[int'(32'h84 >> 2)] = 32'h77777777;
    drive_req(1'b1, 32'h84, 32'h77777777, 4'hF);
    wait_resp(n);
    check("resp_abort_latency", n, LAT);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle_outputs("abort_resp");
    send(1'b0, 32'h84, 32'h0, 4'hF, 0, 1'b0);

    // Reset and req_valid together: nothing latched.
    reset = 1'b1;
    drive_req(1'b1, 32'h80, 32'h99999999, 4'hF);
    reset = 1'b0;
    check_idle_outputs("reset_vs_req");
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("reset_vs_req_no_resp", {31'd0, resp_valid}, 32'd0);
    send(1'b0, 32'h80, 32'h0, 4'hF, 0, 1'b0);

`ifdef DMEM_BYTE_EN
    send(1'b1, 32'h20, 32'h11223344, 4'hF,    0, 1'b0);
    send(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0101, 0, 1'b0);
    send(1'b0, 32'h20, 32'h0,        4'b0000, 0, 1'b0);
    check("be_merge_model", model[int'(32'h20 >> 2)], 32'h11FF33FF);
    send(1'b1, 32'h20, 32'h00000000, 4'b0000, 0, 1'b0);
    send(1'b0, 32'h20, 32'h0,        4'b0011, 0, 1'b0);
`else
    send(1'b1, 32'h20, 32'h11223344, 4'hF,    0, 1'b0);
    send(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0101, 0, 1'b0);
    send(1'b0, 32'h20, 32'h0,        4'hF,    0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
